// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider, optional signed mode under SEQ_DIVIDER_SIGNED_EN
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             sgn_mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] part_q;
    logic [WIDTH-1:0]   dvsr_q;
    logic               dbz_pend_q;
    logic               done_q;
    logic               dbz_q;
    logic [WIDTH-1:0]   quot_q;
    logic [WIDTH-1:0]   rem_q;

    logic [WIDTH-1:0]   dvnd_mag;
    logic [WIDTH-1:0]   dvsr_mag;
    logic [WIDTH:0]     hi;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] part_nx;
    logic [WIDTH-1:0]   quot_fin;
    logic [WIDTH-1:0]   rem_fin;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic               neg_q_q;
    logic               neg_r_q;
    logic [WIDTH-1:0]   dvnd_raw_q;
    logic               dvnd_neg;
    logic               dvsr_neg;
`else
    wire                unused_sgn_mode = sgn_mode;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: CALC runs for WIDTH cycles, FIN lasts one
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (cnt_q == CW'(WIDTH - 1)) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand magnitudes taken at capture time
    always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
        dvnd_neg = sgn_mode & dividend[WIDTH-1];
        dvsr_neg = sgn_mode & divisor[WIDTH-1];
        dvnd_mag = dvnd_neg ? (~dividend + 1'b1) : dividend;
        dvsr_mag = dvsr_neg ? (~divisor + 1'b1) : divisor;
`else
        dvnd_mag = dividend;
        dvsr_mag = divisor;
`endif
    end

    // One restoring step: shift in next dividend bit, trial-subtract, keep if non-negative
    always_comb begin
        hi      = part_q[2*WIDTH-1:WIDTH-1];
        diff    = {1'b0, hi} - {2'b00, dvsr_q};
        part_nx = {part_q[2*WIDTH-2:0], 1'b0};
        if (!diff[WIDTH+1]) begin
            part_nx = {diff[WIDTH-1:0], part_q[WIDTH-2:0], 1'b1};
        end
    end

    // Result with sign correction; divide-by-zero bypasses correction
    always_comb begin
        quot_fin = part_q[WIDTH-1:0];
        rem_fin  = part_q[2*WIDTH-1:WIDTH];
`ifdef SEQ_DIVIDER_SIGNED_EN
        if (dbz_pend_q) begin
            quot_fin = '1;
            rem_fin  = dvnd_raw_q;
        end else begin
            if (neg_q_q) quot_fin = ~part_q[WIDTH-1:0] + 1'b1;
            if (neg_r_q) rem_fin  = ~part_q[2*WIDTH-1:WIDTH] + 1'b1;
        end
`endif
    end

    // Datapath: capture in IDLE, iterate in CALC, publish results in FIN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            part_q     <= '0;
            dvsr_q     <= '0;
            dbz_pend_q <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            dvnd_raw_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q      <= '0;
                        part_q     <= {{WIDTH{1'b0}}, dvnd_mag};
                        dvsr_q     <= dvsr_mag;
                        dbz_pend_q <= (divisor == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
                        neg_q_q    <= dvnd_neg ^ dvsr_neg;
                        neg_r_q    <= dvnd_neg;
                        dvnd_raw_q <= dividend;
`endif
                    end
                end
                CALC: begin
                    part_q <= part_nx;
                    cnt_q  <= cnt_q + 1'b1;
                end
                FIN: begin
                    quot_q <= quot_fin;
                    rem_q  <= rem_fin;
                    dbz_q  <= dbz_pend_q;
                    done_q <= 1'b1;
                    cnt_q  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard testbench for seq_divider (WIDTH=8)
module tb_seq_divider;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             sgn_mode;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         cyc;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .sgn_mode   (sgn_mode),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_quotient"}, 32'(quotient), 32'(e.q));
                chk({e.name, "_remainder"}, 32'(remainder), 32'(e.r));
                chk({e.name, "_dbz"}, 32'(div_by_zero), 32'(e.z));
                chk({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called just after a falling edge; start is accepted on the next rising edge
    task automatic issue(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic push,
                         input logic [7:0] eq, input logic [7:0] er, input logic ez);
        exp_t e;
        dividend = a;
        divisor  = b;
        sgn_mode = s;
        start    = 1'b1;
        if (push) begin
            e.q    = eq;
            e.r    = er;
            e.z    = ez;
            e.cyc  = cyc + WIDTH + 2;
            e.name = name;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        #2;
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #2;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got_done;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        sgn_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #2;

        issue("u100_7", 8'd100, 8'd7, 1'b0, 1'b1, 8'd14, 8'd2, 1'b0);
        chk("busy_in_calc", 32'(busy), 32'd1);
        drain();

        issue("u55_0", 8'd55, 8'd0, 1'b0, 1'b1, 8'hFF, 8'd55, 1'b1);
        drain();

`ifdef SEQ_DIVIDER_SIGNED_EN
        issue("sF9_02", 8'hF9, 8'h02, 1'b1, 1'b1, 8'hFD, 8'hFF, 1'b0);
        drain();
        issue("s80_FF", 8'h80, 8'hFF, 1'b1, 1'b1, 8'h80, 8'h00, 1'b0);
        drain();
`else
        issue("sF9_02", 8'hF9, 8'h02, 1'b1, 1'b1, 8'd124, 8'd1, 1'b0);
        drain();
        issue("s80_FF", 8'h80, 8'hFF, 1'b1, 1'b1, 8'd0, 8'd128, 1'b0);
        drain();
`endif

        // start while busy must neither restart nor recapture
        issue("ign20_3", 8'd20, 8'd3, 1'b0, 1'b1, 8'd6, 8'd2, 1'b0);
        repeat (2) @(negedge clk);
        #2;
        dividend = 8'd99;
        divisor  = 8'd1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
        drain();

        // back-to-back: second start raised in the done cycle
        issue("b2b50_5", 8'd50, 8'd5, 1'b0, 1'b1, 8'd10, 8'd0, 1'b0);
        got_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        chk("b2b_first_done_seen", 32'(got_done), 32'd1);
        #2;
        issue("b2b77_8", 8'd77, 8'd8, 1'b0, 1'b1, 8'd9, 8'd5, 1'b0);
        drain();

        // reset in the 4th CALC cycle clears everything asynchronously
        issue("rst_inflight", 8'd150, 8'd4, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_quotient", 32'(quotient), 32'd0);
        chk("midrst_remainder", 32'(remainder), 32'd0);
        chk("midrst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        issue("u200_9", 8'd200, 8'd9, 1'b0, 1'b1, 8'd22, 8'd2, 1'b0);
        drain();

        repeat (20) @(negedge clk);
        #2;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
